pipe_stage_skid: RTL
====================

# pipe_stage_skid

Parametrised pipeline-stage register with a valid/ready handshake, a two-entry skid buffer, synchronous flush and a saturating stall counter. It is the generic successor to the fixed per-stage latches (IF/ID … MEM/WB): any stage payload, including control word, destination, MAR/MDR and branch-predictor metadata, is carried as one packed vector. Downstream back-pressure no longer needs a global load enable. The block sits between two adjacent pipeline stages of the LC-3b core.

## Interface
- W, 16: payload width in bits (≥1)
- CW, 16: stall-counter width in bits (≥2)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state immediately
- flush  in  1  synchronous kill of all buffered entries (branch mispredict / exception)
- in_valid  in  1  upstream has a payload
- in_ready  out  1  block can accept; = !flush && (count != 2)
- in_data  in  W  upstream payload
- out_valid  out  1  head entry present; = (count != 0)
- out_ready  in  1  downstream consumes head this cycle
- out_data  out  W  head payload
- count  out  2  entries held (0..2)
- stall_cycles  out  CW  saturating count of cycles with out_valid && !out_ready

## Operation
- Storage: head slot H (drives out_data) and skid slot S. push = in_valid && in_ready; pop = out_valid && out_ready.
- State is count ∈ {EMPTY=0, ONE=1, FULL=2}:
  - EMPTY: push → ONE, in_data→H.
  - ONE:
    - push && pop → ONE, in_data→H.
    - push only → FULL, in_data→S.
    - pop only → EMPTY.
    - neither → hold.
  - FULL: in_ready=0.
    - pop → ONE, S→H, S cleared.
    - else hold.
- Flush has highest priority after reset: next edge count=0, H=S=0. A push in the same cycle is impossible (in_ready=0). A pop in the same cycle still completes downstream.
- Slots are zeroed whenever invalidated (pop to EMPTY, S drained, flush), so out_data=0 whenever out_valid=0.
- stall_cycles increments by 1 on each edge where out_valid && !out_ready. It saturates at 2^CW−1 and is cleared only by reset; flush does not clear it.
- Payload is never reordered, duplicated or dropped, except by flush.

## Timing
- Reset values: count=0, out_valid=0, out_data=0, stall_cycles=0. in_ready=1 when flush=0.
- Latency: data pushed at edge N is on out_data with out_valid=1 after edge N (visible in cycle N+1). No combinational in_data→out_data path.
- Throughput: 1 transfer/cycle sustained while out_ready=1.
- Combinational paths:
  - in_ready depends only on flush and registered count. There is no out_ready→in_ready path; that is the purpose of the skid slot.
  - out_valid and out_data are purely registered.
- Boundary conditions:
  - Push and pop together in FULL cannot occur (in_ready=0).
  - Push and pop together in ONE keeps count=1 with the new head.
  - Counter at max plus a stall cycle: the counter holds.
- Reset asserted mid-operation clears everything asynchronously, regardless of clk. Deassertion is assumed synchronised externally. The first push is possible on the first edge after release.

## Structure
- Shared package lc3b_types holds:
  - lc3b_word and lc3b_reg.
  - lc3b_control_word.
  - A packed struct lc3b_stage_payload. Instances set W = $bits(lc3b_stage_payload).
  - Localparams LC3B_LHIST_W=8 and LC3B_GHIST_W=6 for the predictor index fields inside the payload.
- One sub-module is natural: pipe_slot. It is a W-bit register with async reset, load and synchronous clear, and is instantiated twice (H, S). FSM, handshake and counter logic live in pipe_stage_skid.

## Test plan
- Reset asserted mid-cycle with count=2 → count=0, out_valid=0, out_data=0, stall_cycles=0 immediately, before the next edge.
- Stream 0x0001..0x0008 with out_ready=1 → outputs 0x0001..0x0008 in order, one per cycle, first output one cycle after first push, count stays 1.
- Push 0xAAAA, 0xBBBB with out_ready=0:
  - count=2, in_ready=0, stall_cycles increments each cycle.
  - Then out_ready=1 → 0xAAAA then 0xBBBB, count 2→1→0.
- count=2 and flush=1 for one cycle → next cycle count=0, out_data=0, in_ready=1. A subsequent push of 0x1234 appears alone.
- CW=2, hold out_valid with out_ready=0 for 6 cycles → stall_cycles reads 1,2,3,3,3,3. A later reset → 0.
- count=1 (head 0x00FF), push 0x0F0F with out_ready=1 in the same cycle → 0x00FF consumed, next head 0x0F0F, count remains 1.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types.
//   lc3b_word / lc3b_reg    : basic datapath widths
//   lc3b_control_word       : decoded control bits carried down the pipe
//   lc3b_stage_payload      : everything one stage hands to the next, as a
//                             single packed vector (instances use
//                             W = $bits(lc3b_stage_payload))
//   skid_state_e            : occupancy state of pipe_stage_skid
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_reg;

  // Predictor index widths inside the payload.
  localparam int LC3B_LHIST_W = 8;
  localparam int LC3B_GHIST_W = 6;

  typedef struct packed {
    logic [3:0] opcode;
    logic       load_regfile;
    logic       load_cc;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] alu_op;
    logic       br_en;
  } lc3b_control_word;

  typedef struct packed {
    lc3b_control_word          ctrl;
    lc3b_word                  pc;
    lc3b_reg                   dest;
    lc3b_word                  mar;
    lc3b_word                  mdr;
    logic [LC3B_LHIST_W-1:0]   lhist_idx;
    logic [LC3B_GHIST_W-1:0]   ghist;
    logic                      pred_taken;
  } lc3b_stage_payload;

  // Encoding equals the number of held entries, so the state register
  // doubles as the externally visible count.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_slot.sv
// One payload slot of the skid stage: W-bit register with async reset,
// synchronous clear and load. Clear wins over load.
//   clk, rst  : clock, async active-high reset
//   i_load    : capture i_d on the next edge
//   i_clear   : zero the slot on the next edge
//   i_d       : data to load
//   o_q       : registered slot contents
module pipe_slot #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_clear,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_clear) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake, two-entry skid
// buffer (head H, skid S), synchronous flush and saturating stall counter.
//   clk, reset            : clock, async active-high reset
//   flush                 : drop all buffered entries on the next edge
//   in_valid/in_ready/in_data    : upstream handshake and payload
//   out_valid/out_ready/out_data : downstream handshake and head payload
//   count                 : entries held (0..2), also the FSM state
//   stall_cycles          : saturating count of out_valid && !out_ready
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready. in_ready is a function of flush
// and registered state only, so out_ready never reaches in_ready -- the
// skid slot absorbs the one beat accepted while downstream stalls.
module pipe_stage_skid
  import lc3b_types::*;
#(
  parameter int W  = 16,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [1:0]    count,
  output logic [CW-1:0] stall_cycles
);

  localparam logic [CW-1:0] STALL_MAX = '1;

  skid_state_e r_state;
  skid_state_e w_state_nxt;

  logic          w_push;
  logic          w_pop;
  logic          w_h_load;
  logic          w_h_clear;
  logic [W-1:0]  w_h_d;
  logic          w_s_load;
  logic          w_s_clear;
  logic [W-1:0]  w_h_q;
  logic [W-1:0]  w_s_q;
  logic [CW-1:0] r_stall;

  assign in_ready  = !flush && (r_state != SKID_FULL);
  assign out_valid = (r_state != SKID_EMPTY);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= SKID_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and slot controls. Slots are zeroed whenever they become
  // invalid so out_data reads 0 while out_valid is low.
  always_comb begin
    w_state_nxt = r_state;
    w_h_load    = 1'b0;
    w_h_clear   = 1'b0;
    w_h_d       = in_data;
    w_s_load    = 1'b0;
    w_s_clear   = 1'b0;
    if (flush) begin
      // A pop in this cycle still completes downstream; only storage dies.
      w_state_nxt = SKID_EMPTY;
      w_h_clear   = 1'b1;
      w_s_clear   = 1'b1;
    end else begin
      case (r_state)
        SKID_EMPTY: begin
          if (w_push) begin
            w_state_nxt = SKID_ONE;
            w_h_load    = 1'b1;
          end
        end
        SKID_ONE: begin
          if (w_push && w_pop) begin
            w_h_load = 1'b1;
          end else if (w_push) begin
            w_state_nxt = SKID_FULL;
            w_s_load    = 1'b1;
          end else if (w_pop) begin
            w_state_nxt = SKID_EMPTY;
            w_h_clear   = 1'b1;
          end
        end
        SKID_FULL: begin
          if (w_pop) begin
            w_state_nxt = SKID_ONE;
            w_h_load    = 1'b1;
            w_h_d       = w_s_q;
            w_s_clear   = 1'b1;
          end
        end
        default: begin
          w_state_nxt = SKID_EMPTY;
          w_h_clear   = 1'b1;
          w_s_clear   = 1'b1;
        end
      endcase
    end
  end

  pipe_slot #(.W(W)) u_head (
    .clk     (clk),
    .rst     (reset),
    .i_load  (w_h_load),
    .i_clear (w_h_clear),
    .i_d     (w_h_d),
    .o_q     (w_h_q)
  );

  pipe_slot #(.W(W)) u_skid (
    .clk     (clk),
    .rst     (reset),
    .i_load  (w_s_load),
    .i_clear (w_s_clear),
    .i_d     (in_data),
    .o_q     (w_s_q)
  );

  // Flush does not touch the stall counter; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall <= '0;
    end else if (out_valid && !out_ready && (r_stall != STALL_MAX)) begin
      r_stall <= r_stall + 1'b1;
    end
  end

  assign out_data     = w_h_q;
  assign count        = r_state;
  assign stall_cycles = r_stall;

endmodule
